// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
// Holds the FSM encoding, requester ids and the round-robin pick helper.
package addsub_arbiter_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   localparam logic REQ_ID0 = 1'b0;
   localparam logic REQ_ID1 = 1'b1;

   // Under contention the requester that did not win last time goes next.
   function automatic logic pick_requester(input logic req0, input logic req1,
                                           input logic last);
      logic id;
      if (req0 && req1) begin
         id = ~last;
      end else if (req1) begin
         id = REQ_ID1;
      end else begin
         id = REQ_ID0;
      end
      return id;
   endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/grant/result bundle between the two requesters and the arbiter.
// reqN is a level "valid" held until gntN; gntN is a one-cycle accept pulse.
// doneN is a one-cycle result-valid pulse with no back-pressure.
interface addsub_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             sub0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             sub1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] S;
   logic             overflow;
   logic             carry;
   logic             busy;

   modport master (
      output req0, a0, b0, sub0, req1, a1, b1, sub1,
      input  gnt0, gnt1, done0, done1, A, B, S, overflow, carry, busy
   );

   modport slave (
      input  req0, a0, b0, sub0, req1, a1, b1, sub1,
      output gnt0, gnt1, done0, done1, A, B, S, overflow, carry, busy
   );
endinterface

// File: rtl/addsub_arbiter_addsub_unit.sv
// Combinational ripple-carry adder/subtractor built from single-bit full adders.
// Subtraction is A + ~B + 1, so carry = 1 means no borrow.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module addsub_unit #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] s,
   output logic             carry,
   output logic             overflow
);
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   c;

   assign bx   = b ^ {WIDTH{op}};
   assign c[0] = op;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      fulladder u_fa (
         .a    (a[i]),
         .b    (bx[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign carry    = c[WIDTH];
   assign overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters.
// IDLE captures the winner's operands and pulses gnt; EXEC registers the result and pulses done.
module addsub_arbiter
   import addsub_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                    Clock,
   input  logic                    Reset,
   addsub_arbiter_if.slave         bus,
   output state_t                  dbg_state
);

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             ovf_q, ovf_d;
   logic             carry_q, carry_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;

   logic             sel_id;
   logic [WIDTH-1:0] unit_s;
   logic             unit_carry;
   logic             unit_ovf;

   addsub_unit #(.WIDTH(WIDTH)) u_addsub (
      .a        (a_q),
      .b        (b_q),
      .op       (op_q),
      .s        (unit_s),
      .carry    (unit_carry),
      .overflow (unit_ovf)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      s_d     = s_q;
      ovf_d   = ovf_q;
      carry_d = carry_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      sel_id  = pick_requester(bus.req0, bus.req1, last_q);

      case (state_q)
         ST_IDLE: begin
            if (bus.req0 || bus.req1) begin
               last_d  = sel_id;
               a_d     = (sel_id == REQ_ID1) ? bus.a1   : bus.a0;
               b_d     = (sel_id == REQ_ID1) ? bus.b1   : bus.b0;
               op_d    = (sel_id == REQ_ID1) ? bus.sub1 : bus.sub0;
               gnt0_d  = (sel_id == REQ_ID0);
               gnt1_d  = (sel_id == REQ_ID1);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // Requests are not sampled here; a held req is picked up back in IDLE.
            s_d     = unit_s;
            ovf_d   = unit_ovf;
            carry_d = unit_carry;
            done0_d = (last_q == REQ_ID0);
            done1_d = (last_q == REQ_ID1);
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         last_q  <= REQ_ID1;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         s_q     <= '0;
         ovf_q   <= 1'b0;
         carry_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         s_q     <= s_d;
         ovf_q   <= ovf_d;
         carry_q <= carry_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
      end
   end

   assign bus.gnt0     = gnt0_q;
   assign bus.gnt1     = gnt1_q;
   assign bus.done0    = done0_q;
   assign bus.done1    = done1_q;
   assign bus.A        = a_q;
   assign bus.B        = b_q;
   assign bus.S        = s_q;
   assign bus.overflow = ovf_q;
   assign bus.carry    = carry_q;
   assign bus.busy     = (state_q == ST_EXEC);
   assign dbg_state    = state_q;

endmodule
